// File: rtl/pol_ofm_wr_pkg.sv
// Shared pool package: write-FSM state encodings and width helpers.
package pol_ofm_wr_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Bits needed to hold ceil(chi / lanes) for any chi of chn_w bits.
    function automatic int unsigned grp_width(input int unsigned chn_w,
                                              input int unsigned lanes);
        return chn_w - $clog2(lanes) + 2;
    endfunction

    // Pad width so chi + (lanes-1) cannot overflow before the divide.
    function automatic int unsigned pad_width(input int unsigned chn_w,
                                              input int unsigned lanes);
        return chn_w + $clog2(lanes) + 1;
    endfunction

endpackage

// File: rtl/pol_ofm_wr_pow_fifo2.sv
// Two-entry valid/ready FIFO sitting between the pooling core and GLB writes.
module pow_fifo2 #(
    parameter int DW = 512
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          in_vld_i,
    output logic          in_rdy_o,
    input  logic [DW-1:0] in_dat_i,
    output logic          out_vld_o,
    input  logic          out_rdy_i,
    output logic [DW-1:0] out_dat_o
);

    logic [DW-1:0] mem_q [2];
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic [1:0]    cnt_q;
    logic          push;
    logic          pop;

    assign in_rdy_o  = (cnt_q != 2'd2);
    assign out_vld_o = (cnt_q != 2'd0);
    assign out_dat_o = mem_q[rd_ptr_q];
    assign push      = in_vld_i & in_rdy_o;
    assign pop       = out_vld_o & out_rdy_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else if (flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_dat_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/pol_ofm_wr.sv
// Pooled output-feature-map writer: streams pooled words into GLB at Base.
// Optional ReLU clamp on each lane before buffering: POL_OFM_WR_RELU_EN.
module pol_ofm_wr
    import pol_ofm_wr_pkg::*;
#(
    parameter int ACT_WIDTH      = 8,
    parameter int POOL_COMP_CORE = 64,
    parameter int IDX_WIDTH      = 10,
    parameter int CHN_WIDTH      = 12,
    parameter int ADDR_WIDTH     = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                CCUPOW_Rst,
    input  logic                                CCUPOW_CfgVld,
    output logic                                POWCCU_CfgRdy,
    input  logic [IDX_WIDTH-1:0]                CCUPOW_CfgNip,
    input  logic [CHN_WIDTH-1:0]                CCUPOW_CfgChi,
    input  logic [ADDR_WIDTH-1:0]               CCUPOW_CfgBase,
    input  logic                                POLPOW_OfmVld,
    input  logic [ACT_WIDTH*POOL_COMP_CORE-1:0] POLPOW_Ofm,
    output logic                                POWPOL_OfmRdy,
    output logic                                POWGLB_WrVld,
    output logic [ADDR_WIDTH-1:0]               POWGLB_WrAddr,
    output logic [ACT_WIDTH*POOL_COMP_CORE-1:0] POWGLB_WrDat,
    input  logic                                GLBPOW_WrRdy,
    output logic                                POWCCU_Done
);

    localparam int DW = ACT_WIDTH * POOL_COMP_CORE;
    localparam int GW = grp_width(CHN_WIDTH, POOL_COMP_CORE);
    localparam int PW = pad_width(CHN_WIDTH, POOL_COMP_CORE);
    localparam int TW = IDX_WIDTH + GW;

    logic [1:0]            state_q, state_d;
    logic [TW-1:0]         total_q, total_d;
    logic [TW-1:0]         acc_q, acc_d;
    logic [TW-1:0]         wr_cnt_q, wr_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    logic [PW-1:0] chi_pad;
    logic [GW-1:0] grp_cnt;
    logic [TW-1:0] cfg_total;
    logic [DW-1:0] ofm_proc;
    logic          fifo_in_rdy;
    logic          push_hs;
    logic          wr_hs;

    assign chi_pad   = PW'(CCUPOW_CfgChi) + PW'(POOL_COMP_CORE - 1);
    assign grp_cnt   = GW'(chi_pad / PW'(POOL_COMP_CORE));
    assign cfg_total = TW'(CCUPOW_CfgNip) * TW'(grp_cnt);

`ifdef POL_OFM_WR_RELU_EN
    for (genvar gi = 0; gi < POOL_COMP_CORE; gi++) begin : g_relu
        assign ofm_proc[gi*ACT_WIDTH +: ACT_WIDTH] =
            POLPOW_Ofm[gi*ACT_WIDTH + ACT_WIDTH - 1] ? '0 : POLPOW_Ofm[gi*ACT_WIDTH +: ACT_WIDTH];
    end
`else
    assign ofm_proc = POLPOW_Ofm;
`endif

    assign POWCCU_CfgRdy = (state_q == ST_IDLE);
    assign POWCCU_Done   = (state_q == ST_DONE);
    assign POWPOL_OfmRdy = (state_q == ST_WRITE) & fifo_in_rdy & (acc_q < total_q);
    assign POWGLB_WrAddr = addr_q;
    assign push_hs       = POLPOW_OfmVld & POWPOL_OfmRdy;
    assign wr_hs         = POWGLB_WrVld & GLBPOW_WrRdy;

    pow_fifo2 #(
        .DW(DW)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush_i  (CCUPOW_Rst),
        .in_vld_i (push_hs),
        .in_rdy_o (fifo_in_rdy),
        .in_dat_i (ofm_proc),
        .out_vld_o(POWGLB_WrVld),
        .out_rdy_i(GLBPOW_WrRdy),
        .out_dat_o(POWGLB_WrDat)
    );

    always_comb begin
        state_d  = state_q;
        total_d  = total_q;
        acc_d    = acc_q;
        wr_cnt_d = wr_cnt_q;
        addr_d   = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (CCUPOW_CfgVld) begin
                    total_d  = cfg_total;
                    addr_d   = CCUPOW_CfgBase;
                    acc_d    = '0;
                    wr_cnt_d = '0;
                    state_d  = (cfg_total == '0) ? ST_DONE : ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (push_hs) begin
                    acc_d = acc_q + 1'b1;
                end
                if (wr_hs) begin
                    addr_d   = addr_q + 1'b1;
                    wr_cnt_d = wr_cnt_q + 1'b1;
                    if (wr_cnt_q == total_q - 1'b1) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Soft reset wins over everything, including a same-cycle config.
        if (CCUPOW_Rst) begin
            state_d  = ST_IDLE;
            total_d  = '0;
            acc_d    = '0;
            wr_cnt_d = '0;
            addr_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            total_q  <= '0;
            acc_q    <= '0;
            wr_cnt_q <= '0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            total_q  <= total_d;
            acc_q    <= acc_d;
            wr_cnt_q <= wr_cnt_d;
            addr_q   <= addr_d;
        end
    end

endmodule

// File: tb/tb_pol_ofm_wr.sv
// Scoreboard bench for pol_ofm_wr; honours POL_OFM_WR_RELU_EN in its model.
module tb_pol_ofm_wr;

    localparam int ACT = 8;
    localparam int LANES = 64;
    localparam int DW = ACT * LANES;
    localparam int AW = 16;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] dat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          soft_rst = 1'b0;
    logic          cfg_vld = 1'b0;
    logic          cfg_rdy;
    logic [9:0]    cfg_nip = '0;
    logic [11:0]   cfg_chi = '0;
    logic [AW-1:0] cfg_base = '0;
    logic          ofm_vld = 1'b0;
    logic [DW-1:0] ofm = '0;
    logic          ofm_rdy;
    logic          wr_vld;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_dat;
    logic          wr_rdy = 1'b1;
    logic          done;

    exp_t          exp_q[$];
    int            n_tests = 0;
    int            n_fail = 0;
    int            exp_total = 0;
    int            wr_seen = 0;
    int            acc_cnt = 0;
    int            done_cnt = 0;
    int            cyc = 0;
    int            last_wr_cyc = 0;
    logic [AW-1:0] cur_addr = '0;
    bit            abort = 1'b0;
    bit            rnd_rdy = 1'b0;

    always #5 clk = ~clk;

    pol_ofm_wr dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .CCUPOW_Rst    (soft_rst),
        .CCUPOW_CfgVld (cfg_vld),
        .POWCCU_CfgRdy (cfg_rdy),
        .CCUPOW_CfgNip (cfg_nip),
        .CCUPOW_CfgChi (cfg_chi),
        .CCUPOW_CfgBase(cfg_base),
        .POLPOW_OfmVld (ofm_vld),
        .POLPOW_Ofm    (ofm),
        .POWPOL_OfmRdy (ofm_rdy),
        .POWGLB_WrVld  (wr_vld),
        .POWGLB_WrAddr (wr_addr),
        .POWGLB_WrDat  (wr_dat),
        .GLBPOW_WrRdy  (wr_rdy),
        .POWCCU_Done   (done)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] model(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        r = d;
`ifdef POL_OFM_WR_RELU_EN
        for (int l = 0; l < LANES; l++) begin
            if (d[l*ACT + ACT - 1]) r[l*ACT +: ACT] = '0;
        end
`endif
        return r;
    endfunction

    // Monitor: scoreboard pops, hold-while-stalled and Done checks.
    initial begin
        exp_t          e;
        bit            stall_prev = 1'b0;
        bit            rst_prev = 1'b0;
        bit            done_prev = 1'b0;
        logic [AW-1:0] prev_addr = '0;
        logic [DW-1:0] prev_dat = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (stall_prev && !rst_prev) begin
                    chk("hold_vld", DW'(wr_vld), DW'(1));
                    chk("hold_addr", DW'(wr_addr), DW'(prev_addr));
                    chk("hold_dat", wr_dat, prev_dat);
                end
                if (wr_vld && wr_rdy) begin
                    if (exp_q.size() == 0) begin
                        chk("unexp_wr", DW'(1), DW'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_addr", DW'(wr_addr), DW'(e.addr));
                        chk("wr_dat", wr_dat, e.dat);
                    end
                    $display("[TB] write addr=%04h", wr_addr);
                    wr_seen++;
                    last_wr_cyc = cyc;
                end
                if (done) begin
                    done_cnt++;
                    chk("done_nwr", DW'(wr_seen), DW'(exp_total));
                    chk("done_qempty", DW'(exp_q.size()), DW'(0));
                    if (exp_total > 0) chk("done_lat", DW'(cyc - last_wr_cyc), DW'(1));
                    if (done_prev) chk("done_width", DW'(0), DW'(1));
                end
                stall_prev = wr_vld && !wr_rdy;
                rst_prev   = soft_rst;
                done_prev  = done;
                prev_addr  = wr_addr;
                prev_dat   = wr_dat;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_rdy) wr_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic do_cfg(input int nip, input int chi, input int base);
        int t = 0;
        while (!cfg_rdy) begin
            @(negedge clk);
            t++;
            if (t > 200) begin
                chk("cfg_timeout", DW'(0), DW'(1));
                return;
            end
        end
        exp_total = nip * ((chi + LANES - 1) / LANES);
        cur_addr  = AW'(base);
        wr_seen   = 0;
        acc_cnt   = 0;
        @(posedge clk);
        #1;
        cfg_vld  = 1'b1;
        cfg_nip  = 10'(nip);
        cfg_chi  = 12'(chi);
        cfg_base = AW'(base);
        @(posedge clk);
        #1;
        cfg_vld = 1'b0;
    endtask

    task automatic feed(input int n, input bit gaps);
        logic [DW-1:0] d;
        int t;
        for (int k = 0; k < n; k++) begin
            for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom();
            if (k == 0) begin
                d[7:0]  = 8'h80;
                d[15:8] = 8'h7F;
            end
            if (gaps && $urandom_range(0, 2) == 0) begin
                @(posedge clk);
                #1;
            end
            ofm_vld = 1'b1;
            ofm = d;
            t = 0;
            forever begin
                @(negedge clk);
                if (abort) begin
                    ofm_vld = 1'b0;
                    return;
                end
                if (ofm_rdy) break;
                t++;
                if (t > 500) begin
                    chk("feed_timeout", DW'(0), DW'(1));
                    ofm_vld = 1'b0;
                    return;
                end
            end
            @(posedge clk);
            exp_q.push_back('{addr: cur_addr, dat: model(d)});
            cur_addr = cur_addr + 1'b1;
            acc_cnt++;
            #1;
            ofm_vld = 1'b0;
        end
    endtask

    task automatic wait_done();
        int d0 = done_cnt;
        int t = 0;
        while (done_cnt == d0) begin
            @(negedge clk);
            t++;
            if (t > 2000) begin
                chk("done_timeout", DW'(0), DW'(1));
                return;
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_writes(input int n);
        int t = 0;
        while (wr_seen < n) begin
            @(negedge clk);
            t++;
            if (t > 500) begin
                chk("wr_timeout", DW'(wr_seen), DW'(n));
                return;
            end
        end
    endtask

    initial begin
        int d0;
        repeat (3) @(negedge clk);
        chk("rst_cfgrdy", DW'(cfg_rdy), DW'(1));
        chk("rst_ofmrdy", DW'(ofm_rdy), DW'(0));
        chk("rst_wrvld", DW'(wr_vld), DW'(0));
        chk("rst_wraddr", DW'(wr_addr), DW'(0));
        chk("rst_wrdat", wr_dat, DW'(0));
        chk("rst_done", DW'(done), DW'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Basic stream with GLB always ready.
        do_cfg(4, 64, 'h100);
        feed(4, 1'b0);
        wait_done();

        // Multi-group channel count with input gaps.
        do_cfg(3, 130, 'h020);
        feed(9, 1'b1);
        wait_done();

        // Address wrap with a randomly throttled GLB.
        rnd_rdy = 1'b1;
        do_cfg(4, 1, 'hFFFE);
        feed(4, 1'b1);
        wait_done();
        rnd_rdy = 1'b0;
        #1;
        wr_rdy = 1'b1;

        // Five-cycle GLB stall mid-stream.
        do_cfg(6, 64, 'h040);
        fork
            feed(6, 1'b0);
            begin
                wait_writes(2);
                @(posedge clk);
                #1;
                wr_rdy = 1'b0;
                repeat (3) @(negedge clk);
                chk("stall_ofmrdy", DW'(ofm_rdy), DW'(0));
                chk("stall_fill", DW'(acc_cnt - wr_seen), DW'(2));
                repeat (3) @(posedge clk);
                #1;
                wr_rdy = 1'b1;
            end
        join
        wait_done();

        // Soft reset after two of eight writes.
        do_cfg(8, 64, 'h200);
        fork
            feed(8, 1'b0);
            begin
                wait_writes(2);
                @(posedge clk);
                #1;
                abort    = 1'b1;
                wr_rdy   = 1'b0;
                soft_rst = 1'b1;
                d0 = done_cnt;
                @(posedge clk);
                #1;
                soft_rst = 1'b0;
                @(negedge clk);
                chk("srst_wrvld", DW'(wr_vld), DW'(0));
                chk("srst_cfgrdy", DW'(cfg_rdy), DW'(1));
                chk("srst_ofmrdy", DW'(ofm_rdy), DW'(0));
                exp_q.delete();
                repeat (5) @(negedge clk);
                chk("srst_nodone", DW'(done_cnt), DW'(d0));
            end
        join
        abort = 1'b0;
        @(posedge clk);
        #1;
        wr_rdy = 1'b1;
        do_cfg(2, 64, 'h300);
        feed(2, 1'b0);
        wait_done();

        // Zero-size jobs finish immediately.
        do_cfg(0, 64, 'h500);
        @(negedge clk);
        chk("nip0_done", DW'(done), DW'(1));
        @(negedge clk);
        chk("nip0_done_end", DW'(done), DW'(0));
        chk("nip0_nwr", DW'(wr_seen), DW'(0));
        do_cfg(5, 0, 'h600);
        @(negedge clk);
        chk("chi0_done", DW'(done), DW'(1));
        @(negedge clk);
        chk("chi0_nwr", DW'(wr_seen), DW'(0));

        repeat (3) @(negedge clk);
        chk("final_qempty", DW'(exp_q.size()), DW'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pol_ofm_wr.md
POL_OFM_WR -- requirements
Module: pol_ofm_wr

Interface
REQ-001 SHALL have parameter ACT_WIDTH, default 8, activation lane width in bits.
REQ-002 SHALL have parameter POOL_COMP_CORE, default 64, lanes per output word.
REQ-003 SHALL have parameter IDX_WIDTH, default 10, point-count width.
REQ-004 SHALL have parameter CHN_WIDTH, default 12, channel-count width.
REQ-005 SHALL have parameter ADDR_WIDTH, default 16, GLB write-address width.
REQ-006 SHALL have ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
CCUPOW_Rst  in  1  synchronous soft reset
CCUPOW_CfgVld  in  1  config valid
POWCCU_CfgRdy  out  1  config ready
CCUPOW_CfgNip  in  IDX_WIDTH  output point count
CCUPOW_CfgChi  in  CHN_WIDTH  channel count
CCUPOW_CfgBase  in  ADDR_WIDTH  GLB base address
POLPOW_OfmVld  in  1  pooled word valid
POLPOW_Ofm  in  ACT_WIDTH*POOL_COMP_CORE  pooled word
POWPOL_OfmRdy  out  1  pooled word ready
POWGLB_WrVld  out  1  write valid
POWGLB_WrAddr  out  ADDR_WIDTH  write address
POWGLB_WrDat  out  ACT_WIDTH*POOL_COMP_CORE  write data
GLBPOW_WrRdy  in  1  write ready
POWCCU_Done  out  1  one-cycle completion pulse

Function
REQ-007 SHALL implement states IDLE, WRITE, DONE; POWCCU_CfgRdy = (state==IDLE).
REQ-008 SHALL on CfgVld&CfgRdy latch Nip, Chi, Base and compute Total = Nip * ceil(Chi/POOL_COMP_CORE), then go to WRITE.
REQ-009 SHALL go IDLE->DONE directly when Total==0 (Nip==0 or Chi==0).
REQ-010 SHALL buffer input words in a 2-entry FIFO; POWPOL_OfmRdy = (state==WRITE) & FIFO not full & accepted count < Total.
REQ-011 SHALL drive POWGLB_WrVld = FIFO not empty, WrDat = FIFO head; a word accepted in cycle N SHALL be presented at earliest cycle N+1.
REQ-012 SHALL hold WrVld/WrAddr/WrDat stable while WrVld&!WrRdy.
REQ-013 SHALL start WrAddr at latched Base and increment by 1 per write handshake, wrapping modulo 2^ADDR_WIDTH.
REQ-014 SHALL sustain one write per cycle with simultaneous FIFO push and pop.
REQ-015 SHALL transition WRITE->DONE on the handshake of write number Total; DONE SHALL last exactly one cycle with POWCCU_Done=1, then IDLE.
REQ-016 SHALL ignore CfgVld outside IDLE.

Reset
REQ-017 SHALL on rst_n low asynchronously clear state to IDLE, FIFO to empty, counters to 0; outputs: CfgRdy=1, OfmRdy=0, WrVld=0, WrAddr=0, WrDat=0, Done=0.
REQ-018 SHALL on CCUPOW_Rst (any state) return to IDLE next cycle, flush FIFO, clear counters, no Done pulse.

Configuration
REQ-019 SHALL with macro POL_OFM_WR_RELU_EN defined clamp each signed ACT_WIDTH lane of POLPOW_Ofm to 0 if negative before the FIFO; without it data SHALL pass unchanged.

Structure
REQ-020 SHALL place state encodings and ceil-divide width constants in the shared pool package.
REQ-021 SHALL implement the FIFO as sub-module pow_fifo2 (2-entry, valid/ready both sides).

Verification
REQ-022 Nip=4, Chi=64, Base=0x100, WrRdy=1 -> 4 writes at 0x100..0x103, Done one cycle after 4th write.
REQ-023 Nip=3, Chi=130 -> Total=9 writes, addresses Base..Base+8, Done once.
REQ-024 Base=0xFFFE, Total=4 -> addresses 0xFFFE,0xFFFF,0x0000,0x0001.
REQ-025 WrRdy low 5 cycles mid-stream -> WrVld/Addr/Dat stable, OfmRdy drops after 2 buffered words, no data lost or reordered.
REQ-026 CCUPOW_Rst after 2 of 8 writes -> IDLE next cycle, WrVld=0, no Done; new config then runs cleanly from its Base.
REQ-027 Nip=0 -> Done pulse 1 cycle after config, zero writes; with POL_OFM_WR_RELU_EN lane 0x80 written as 0x00, lane 0x7F unchanged.
